// File: rtl/pe_arr_seq.sv
// Sequencer for the 2-D systolic PE array: reads K operand vectors, skews them, fires, waits for drain.
// Latency: rd_en from cycle 1 after start; lane d presents k=0 on cycle 3+d; done 1 cycle after last_valid.
// Backpressure: none; start is ignored while busy, abort returns to IDLE on the next cycle.
//
// Ports:
//   clk, rstn                : clock, asynchronous active-low reset
//   start, k_len, abort      : tile command (k_len latched on accepted start), synchronous abort
//   busy, done, err          : status; done/err is a one-cycle pulse, err = timeout or k_len==0
//   rd_en, rd_addr           : operand buffer read port (1-cycle read latency)
//   w_rdata, a_rdata         : weight / activation vectors returned by the buffers
//   arr_in_w, arr_in_a       : diagonally skewed operands to the array edges
//   arr_fire, last_valid     : fire token to PE(0,0), result-valid from PE(ROWS-1,COLS-1)
module pe_arr_seq #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int INWIDTH     = 8,
  parameter int KMAX        = 256,
  parameter int DRAIN_SLACK = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [$clog2(KMAX+1)-1:0]    k_len,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         rd_en,
  output logic [$clog2(KMAX)-1:0]      rd_addr,
  input  logic [COLS*INWIDTH-1:0]      w_rdata,
  input  logic [ROWS*INWIDTH-1:0]      a_rdata,
  output logic [COLS*INWIDTH-1:0]      arr_in_w,
  output logic [ROWS*INWIDTH-1:0]      arr_in_a,
  output logic                         arr_fire,
  input  logic                         last_valid
);

  localparam int KW    = $clog2(KMAX+1);
  localparam int AW    = $clog2(KMAX);
  localparam int CW    = $clog2(KMAX+ROWS+COLS+DRAIN_SLACK+1);
  localparam int EXTRA = ROWS + COLS + DRAIN_SLACK;
  localparam int DEPTH = (ROWS > COLS) ? ROWS : COLS;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic [KW-1:0]     kq;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     limit;
  logic              kill;

  // Abort only has an effect outside IDLE.
  assign kill  = abort && (state != IDLE);
  assign limit = CW'(kq) + CW'(EXTRA);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      kq      <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (kill) begin
        state   <= IDLE;
        busy    <= 1'b0;
        rd_en   <= 1'b0;
        rd_addr <= '0;
        cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (k_len == '0) begin
                state <= DONE;
                done  <= 1'b1;
                err   <= 1'b1;
              end else begin
                kq      <= k_len;
                cnt     <= '0;
                rd_addr <= '0;
                rd_en   <= 1'b1;
                busy    <= 1'b1;
                state   <= READ;
              end
            end
          end
          READ: begin
            if (rd_addr == AW'(kq - KW'(1))) begin
              rd_en   <= 1'b0;
              rd_addr <= '0;
              cnt     <= '0;
              state   <= DRAIN;
            end else begin
              rd_addr <= rd_addr + AW'(1);
            end
          end
          DRAIN: begin
            if (last_valid) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (cnt + CW'(1) == limit) begin
              // DRAIN has lasted kq+ROWS+COLS+DRAIN_SLACK cycles without a result.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;  // DONE
        endcase
      end
    end
  end

  // Valid chain shared by all lanes: rvld marks rdata valid, vpipe[d] marks lane d output valid.
  logic             rvld;
  logic             fire_p;
  logic [DEPTH-1:0] vpipe;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvld     <= 1'b0;
      fire_p   <= 1'b0;
      arr_fire <= 1'b0;
      vpipe    <= '0;
    end else if (kill) begin
      rvld     <= 1'b0;
      fire_p   <= 1'b0;
      arr_fire <= 1'b0;
      vpipe    <= '0;
    end else begin
      rvld     <= rd_en;
      // Fire tracks the k=0 read so it lands with lane 0's first operand.
      fire_p   <= rd_en && (rd_addr == '0);
      arr_fire <= fire_p;
      vpipe[0] <= rvld;
      for (int i = 1; i < DEPTH; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  // Lane j of the weights passes through j+1 stages; output zeroed when its valid bit is low.
  for (genvar j = 0; j < COLS; j++) begin : g_w
    logic [INWIDTH-1:0] sr [j+1];
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int s = 0; s <= j; s++) sr[s] <= '0;
      end else begin
        sr[0] <= w_rdata[j*INWIDTH +: INWIDTH];
        for (int s = 1; s <= j; s++) sr[s] <= sr[s-1];
      end
    end
    assign arr_in_w[j*INWIDTH +: INWIDTH] = vpipe[j] ? sr[j] : '0;
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_a
    logic [INWIDTH-1:0] sr [i+1];
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int s = 0; s <= i; s++) sr[s] <= '0;
      end else begin
        sr[0] <= a_rdata[i*INWIDTH +: INWIDTH];
        for (int s = 1; s <= i; s++) sr[s] <= sr[s-1];
      end
    end
    assign arr_in_a[i*INWIDTH +: INWIDTH] = vpipe[i] ? sr[i] : '0;
  end

endmodule
